// File: rtl/writeback_arbiter.sv
// writeback_arbiter: buffers register-write results from NUM_SRC producers in
// per-source FIFOs and arbitrates the FIFO heads onto NUM_WPORTS registered
// register-file/forwarding write ports (fixed priority or round-robin).
module writeback_arbiter #(
    parameter int NUM_SRC    = 2,
    parameter int NUM_WPORTS = 1,
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int ARB_MODE   = 0,
    localparam int SRC_ID_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [NUM_SRC-1:0]               src_valid,
    output logic [NUM_SRC-1:0]               src_ready,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]    src_rd,
    input  logic [NUM_SRC*XLEN-1:0]          src_data,
    output logic [NUM_WPORTS-1:0]            wb_we,
    output logic [NUM_WPORTS*REG_ADDR_W-1:0] wb_rd,
    output logic [NUM_WPORTS*XLEN-1:0]       wb_data,
    output logic [NUM_WPORTS*SRC_ID_W-1:0]   wb_src,
    output logic [NUM_SRC*CNT_W-1:0]         src_count
);

    logic [REG_ADDR_W-1:0] mem_rd   [NUM_SRC][FIFO_DEPTH];
    logic [XLEN-1:0]       mem_data [NUM_SRC][FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr   [NUM_SRC];
    logic [PTR_W-1:0]      rd_ptr   [NUM_SRC];
    logic [CNT_W-1:0]      count    [NUM_SRC];
    logic [SRC_ID_W-1:0]   rr_ptr;

    logic [NUM_SRC-1:0]    enq;
    logic [NUM_SRC-1:0]    deq;
    logic [REG_ADDR_W-1:0] head_rd   [NUM_SRC];
    logic [XLEN-1:0]       head_data [NUM_SRC];

    logic [NUM_WPORTS-1:0] grant_we;
    logic [REG_ADDR_W-1:0] grant_rd   [NUM_WPORTS];
    logic [XLEN-1:0]       grant_data [NUM_WPORTS];
    logic [SRC_ID_W-1:0]   grant_src  [NUM_WPORTS];
    logic [SRC_ID_W-1:0]   rr_next;

    // Handshake, enqueue qualification (x0 writes are accepted but dropped) and head views.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_ready[i] = (count[i] != CNT_W'(FIFO_DEPTH)) && !rst && !flush;
            enq[i]       = src_valid[i] && src_ready[i] &&
                           (src_rd[i*REG_ADDR_W +: REG_ADDR_W] != '0);
            head_rd[i]   = mem_rd[i][rd_ptr[i]];
            head_data[i] = mem_data[i][rd_ptr[i]];
            src_count[i*CNT_W +: CNT_W] = count[i];
        end
    end

    // Scan non-empty heads in priority order, granting up to NUM_WPORTS distinct rds.
    always_comb begin
        int   n;
        int   pos;
        logic clash;
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        n       = 0;
        pos     = 0;
        clash   = 1'b0;
        deq     = '0;
        grant_we = '0;
        rr_next = rr_ptr;
        for (int k = 0; k < NUM_WPORTS; k++) begin
            grant_rd[k]   = '0;
            grant_data[k] = '0;
            grant_src[k]  = '0;
        end
        if (!rst && !flush) begin
            for (int j = 0; j < NUM_SRC; j++) begin
                pos = (ARB_MODE == 1) ? (int'(rr_ptr) + j) % NUM_SRC : j;
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (i == pos) begin
                        clash = 1'b0;
                        for (int k = 0; k < NUM_WPORTS; k++) begin
                            if (k < n && grant_rd[k] == head_rd[i]) clash = 1'b1;
                        end
                        if (count[i] != '0 && !clash && n < NUM_WPORTS) begin
                            deq[i] = 1'b1;
                            for (int k = 0; k < NUM_WPORTS; k++) begin
                                if (k == n) begin
                                    grant_we[k]   = 1'b1;
                                    grant_rd[k]   = head_rd[i];
                                    grant_data[k] = head_data[i];
                                    grant_src[k]  = SRC_ID_W'(i);
                                end
                            end
                            rr_next = SRC_ID_W'((i + 1) % NUM_SRC);
                            n = n + 1;
                        end
                    end
                end
            end
        end
    end

    // FIFO storage writes.
    // NOTE: the entry arrays are not reset; count and pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (enq[i]) begin
                mem_rd[i][wr_ptr[i]]   <= src_rd[i*REG_ADDR_W +: REG_ADDR_W];
                mem_data[i][wr_ptr[i]] <= src_data[i*XLEN +: XLEN];
            end
        end
    end

    // FIFO pointers/occupancy, round-robin pointer and registered write ports.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr  <= '0;
            wb_we   <= '0;
            wb_rd   <= '0;
            wb_data <= '0;
            wb_src  <= '0;
        end else if (flush) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            wb_we   <= '0;
            wb_rd   <= '0;
            wb_data <= '0;
            wb_src  <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (enq[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (deq[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
                count[i] <= count[i] + CNT_W'(enq[i]) - CNT_W'(deq[i]);
            end
            rr_ptr <= rr_next;
            for (int k = 0; k < NUM_WPORTS; k++) begin
                wb_we[k]                             <= grant_we[k];
                wb_rd[k*REG_ADDR_W +: REG_ADDR_W]    <= grant_rd[k];
                wb_data[k*XLEN +: XLEN]              <= grant_data[k];
                wb_src[k*SRC_ID_W +: SRC_ID_W]       <= grant_src[k];
            end
        end
    end

endmodule
